if_fetch: RTL and testbench

//  Instruction-fetch front end: reader of the synchronous 1024x32 instruction ROM (addr in, instr 1 clk later).

---
 rtl/if_fetch_pkg.sv | 16 +
 rtl/if_fetch.sv | 93 +++++++++
 tb/tb_if_fetch.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package if_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // Which source drives the ROM address this cycle, highest priority first.
  typedef enum logic [1:0] {
    SEL_REDIRECT,
    SEL_REPLAY,
    SEL_FETCH,
    SEL_IDLE
  } issue_sel_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch front end: drives the synchronous instruction ROM,
// tags each returned word with its PC and hands it to decode via valid/ready.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic [31:0]       fetch_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] cnt_q, cnt_d;

  issue_sel_e  issue_sel;
  logic [31:0] issue_pc;

  // Pick the issue source: redirect beats a stalled replay, which beats a new fetch.
  always_comb begin
    issue_sel = SEL_IDLE;
    issue_pc  = pc_q;
    if (redirect_valid) begin
      issue_sel = SEL_REDIRECT;
      issue_pc  = redirect_pc & ~32'd3;
    end else if (rsp_vld_q && !id_ready) begin
      issue_sel = SEL_REPLAY;
      issue_pc  = rsp_pc_q;
    end else if (fetch_en) begin
      issue_sel = SEL_FETCH;
      issue_pc  = pc_q;
    end
  end

  // Next-state for PC, response tag and accepted-word counter.
  always_comb begin
    pc_d      = pc_q;
    rsp_pc_d  = rsp_pc_q;
    rsp_vld_d = rsp_vld_q;
    cnt_d     = cnt_q;
    unique case (issue_sel)
      SEL_REDIRECT, SEL_FETCH: begin
        rsp_pc_d  = issue_pc;
        rsp_vld_d = 1'b1;
        pc_d      = issue_pc + PC_STEP;
      end
      SEL_REPLAY: begin
        rsp_vld_d = rsp_vld_q;
      end
      default: begin
        rsp_vld_d = 1'b0;
      end
    endcase
    if (if_valid && id_ready) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      rsp_pc_q  <= '0;
      rsp_vld_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      rsp_pc_q  <= rsp_pc_d;
      rsp_vld_q <= rsp_vld_d;
      cnt_q     <= cnt_d;
    end
  end

  // Word address aliases modulo the ROM depth; a redirect kills the word on the output.
  assign rom_addr  = issue_pc[ADDR_W+1:2];
  assign if_valid  = rsp_vld_q & ~redirect_valid;
  assign if_instr  = rom_instr;
  assign if_pc     = rsp_pc_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch with a behavioural 1024x32 synchronous ROM.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [9:0]  rom_addr;
  logic [31:0] rom_instr = '0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] fetch_cnt;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_cnt = '0;
  logic [31:0] rom_mem [0:1023];

  if_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_instr(rom_instr), .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Fixed test program at words 0..4, NOP elsewhere; PCs alias modulo 1024 words.
  function automatic logic [31:0] prog_word(input logic [31:0] pc);
    logic [9:0] w;
    w = pc[11:2];
    case (w)
      10'd0:   return 32'h001a8193;
      10'd1:   return 32'h00250213;
      10'd2:   return 32'h00330313;
      10'd3:   return 32'h00a183b3;
      10'd4:   return 32'h004a8433;
      default: return 32'h00000013;
    endcase
  endfunction

  // Synchronous ROM: data for the address presented in the previous cycle.
  always @(posedge clk) rom_instr <= rom_mem[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pops an expected PC for every accepted word and checks the counter.
  task automatic run_monitor();
    logic [31:0] pc_e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cnt = '0;
      end else begin
        total++;
        if (fetch_cnt !== exp_cnt) begin
          bad++;
          $display("FAIL fetch_cnt: got %0d want %0d", fetch_cnt, exp_cnt);
        end
        if (if_valid && id_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_word: got pc=%h instr=%h want none", if_pc, if_instr);
          end else begin
            pc_e = exp_q.pop_front();
            if (if_pc !== pc_e) begin
              bad++;
              $display("FAIL word_pc: got %h want %h", if_pc, pc_e);
            end
            total++;
            if (if_instr !== prog_word(pc_e)) begin
              bad++;
              $display("FAIL word_instr: got %h want %h (pc %h)", if_instr, prog_word(pc_e), pc_e);
            end
          end
          exp_cnt = exp_cnt + 32'd1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) tick();
    @(negedge clk);
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", if_pc); end
    total++; if (fetch_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL release_valid: got %b want 0", if_valid); end
    total++; if (rom_addr !== 10'd0) begin bad++; $display("FAIL release_addr: got %0d want 0", rom_addr); end
  endtask

  task automatic test_stream();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL stream_valid: got %b want 1", if_valid); end
    end
  endtask

  task automatic test_stall();
    exp_q.push_back(32'h8);
    tick();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", if_valid); end
      total++; if (if_pc !== 32'h8) begin bad++; $display("FAIL stall_pc: got %h want 8", if_pc); end
      total++; if (if_instr !== 32'h00330313) begin bad++; $display("FAIL stall_instr: got %h want 00330313", if_instr); end
      total++; if (rom_addr !== 10'd2) begin bad++; $display("FAIL stall_addr: got %0d want 2", rom_addr); end
    end
    tick();
    id_ready = 1'b1;
  endtask

  task automatic test_redirect();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0006;
    @(negedge clk);
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_kill: got %b want 0", if_valid); end
    total++; if (rom_addr !== 10'd1) begin bad++; $display("FAIL redir_addr: got %0d want 1", rom_addr); end
    exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (if_pc !== 32'h4) begin bad++; $display("FAIL redir_target: got %h want 4", if_pc); end
    tick();
  endtask

  task automatic test_redirect_prio();
    tick();
    id_ready = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0010;
    @(negedge clk);
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL prio_kill: got %b want 0", if_valid); end
    total++; if (rom_addr !== 10'd4) begin bad++; $display("FAIL prio_addr: got %0d want 4", rom_addr); end
    exp_q.push_back(32'h10); exp_q.push_back(32'h14);
  endtask

  task automatic test_fetch_en();
    tick();
    redirect_valid = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h10) begin bad++; $display("FAIL prio_target: got v=%b pc=%h want v=1 pc=10", if_valid, if_pc); end
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL fen_bubble: got %b want 0", if_valid); end
    end
    total++; if (rom_addr !== 10'd5) begin bad++; $display("FAIL fen_addr: got %0d want 5", rom_addr); end
    tick();
    fetch_en = 1'b1;
    @(negedge clk);
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL fen_resume_bubble: got %b want 0", if_valid); end
    tick();
    @(negedge clk);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h14) begin bad++; $display("FAIL fen_resume: got v=%b pc=%h want v=1 pc=14", if_valid, if_pc); end
  endtask

  task automatic test_stall_disabled();
    exp_q.push_back(32'h18);
    tick();
    id_ready = 1'b0; fetch_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h18) begin bad++; $display("FAIL hold_disabled: got v=%b pc=%h want v=1 pc=18", if_valid, if_pc); end
    end
    tick();
    id_ready = 1'b1;
    tick();
    @(negedge clk);
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL idle_after_hold: got %b want 0", if_valid); end
  endtask

  task automatic test_alias();
    tick();
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0FFC;
    @(negedge clk);
    total++; if (rom_addr !== 10'd1023) begin bad++; $display("FAIL alias_top: got %0d want 1023", rom_addr); end
    exp_q.push_back(32'h0FFC); exp_q.push_back(32'h1000);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (rom_addr !== 10'd0) begin bad++; $display("FAIL alias_wrap: got %0d want 0", rom_addr); end
    tick();
    @(negedge clk);
    total++; if (if_pc !== 32'h1000 || if_instr !== 32'h001a8193) begin bad++; $display("FAIL alias_word: got pc=%h instr=%h want pc=1000 instr=001a8193", if_pc, if_instr); end
  endtask

  task automatic test_reset_mid();
    tick();
    rst_n = 1'b0;
    #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", if_valid); end
    total++; if (fetch_cnt !== 32'h0) begin bad++; $display("FAIL midrst_cnt: got %0d want 0", fetch_cnt); end
    tick();
    rst_n = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    tick();
    @(negedge clk);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL midrst_first: got v=%b pc=%h want v=1 pc=0", if_valid, if_pc); end
    tick();
    @(negedge clk);
    total++; if (if_pc !== 32'h4) begin bad++; $display("FAIL midrst_second: got %h want 4", if_pc); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = prog_word(32'(i) << 2);
    fork
      run_monitor();
    join_none
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_prio();
    test_fetch_en();
    test_stall_disabled();
    test_alias();
    test_reset_mid();
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
